neuron_mac_act: RTL and testbench

//  Per-neuron multiply-accumulate stage that sits directly upstream of the tanh lookup table.
//  - Streams in (x, w) operand pairs and adds the bias.
//  - Rescales the sum to N-bit fixed point and drives the result as the LUT address.
//  - Captures the LUT result one cycle later and offers it downstream on a valid/ready handshake.
//  - One instance is used per hidden-layer neuron in the network datapath.

---
 rtl/neuron_mac_act.sv | 128 ++++++++++++
 tb/tb_neuron_mac_act.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_act.sv
// neuron_mac_act
//   Per-neuron multiply-accumulate stage that feeds the tanh lookup table.
//   It streams in (x, w) beats and adds the bias, which is sampled on the
//   first beat. On the last beat it rescales the sum to N-bit Q-format and
//   registers the result as the LUT address. One cycle later it captures the
//   LUT output and offers it downstream on a valid/ready handshake.
//
//   Ports
//     clk, rst            clock; synchronous active-high reset
//     in_valid/in_ready   operand beat handshake (in_x, in_w, in_last, bias)
//     lut_addr            registered tanh LUT address, stable while looking up
//     tanh_in             LUT data, registered by the LUT on negedge
//     act_valid/act_ready activation handshake carrying act_data
//     ovf                 sticky: a neuron received more than MAX_TERMS beats
//
//   Configuration macro NEURON_SAT_EN
//     defined   : the rescaled sum saturates to the signed N-bit range
//     undefined : the rescaled sum is truncated to its low N bits (wraps)

module neuron_mac_act #(
  parameter  int N         = 8,
  parameter  int Q         = 7,
  parameter  int MAX_TERMS = 16,
  localparam int ACC_W     = 2*N + $clog2(MAX_TERMS) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_w,
  input  logic         in_last,
  input  logic [N-1:0] bias,
  output logic [N-1:0] lut_addr,
  input  logic [N-1:0] tanh_in,
  output logic         act_valid,
  input  logic         act_ready,
  output logic [N-1:0] act_data,
  output logic         ovf
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {S_ACC, S_LOOK, S_HOLD} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic                    first;
  logic [CNT_W-1:0]        term_cnt;

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic [N-1:0]            addr_next;
`ifdef NEURON_SAT_EN
  logic [ACC_W-Q-1:0]      scaled;
`endif

  always_comb begin
    // Operands sign-extend to 2N bits; (-2^(N-1))^2 still fits.
    prod     = $signed(in_x) * $signed(in_w);
    acc_base = first ? ({{(ACC_W-N){bias[N-1]}}, bias} <<< Q) : acc;
    acc_next = acc_base + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
`ifdef NEURON_SAT_EN
    // Dropping the low Q bits is an arithmetic shift right (floor).
    scaled = acc_next[ACC_W-1:Q];
    // In range when every bit above the N-bit sign position matches it.
    if ((&scaled[ACC_W-Q-1:N-1]) || ~(|scaled[ACC_W-Q-1:N-1]))
      addr_next = scaled[N-1:0];
    else
      addr_next = {scaled[ACC_W-Q-1], {(N-1){~scaled[ACC_W-Q-1]}}};
`else
    addr_next = acc_next[Q+N-1:Q];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      acc       <= '0;
      first     <= 1'b1;
      term_cnt  <= '0;
      lut_addr  <= '0;
      act_data  <= '0;
      act_valid <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        S_ACC: begin
          if (in_valid && in_ready) begin
            acc   <= acc_next;
            first <= 1'b0;
            // Count saturates at MAX_TERMS; ovf is sticky so further beats
            // only need to keep re-asserting it.
            if (term_cnt == CNT_W'(MAX_TERMS))
              ovf <= 1'b1;
            else
              term_cnt <= term_cnt + 1'b1;
            if (in_last) begin
              lut_addr <= addr_next;
              in_ready <= 1'b0;
              state    <= S_LOOK;
            end
          end
        end
        S_LOOK: begin
          act_data  <= tanh_in;
          act_valid <= 1'b1;
          first     <= 1'b1;
          term_cnt  <= '0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (act_ready) begin
            act_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_ACC;
          end
        end
        default: begin
          state <= S_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_act.sv
// Bench for neuron_mac_act (N=8, Q=7, MAX_TERMS=16). A transaction-level
// model keeps the products of the current neuron in a queue, folds them with
// plain integer arithmetic on the last beat and predicts the handshake
// signals cycle by cycle. A tanh LUT emulation drives tanh_in on negedge.

module tb_neuron_mac_act;

  localparam int N         = 8;
  localparam int Q         = 7;
  localparam int MAX_TERMS = 16;
  localparam int ACC_W     = 2*N + $clog2(MAX_TERMS) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_w;
  logic       in_last;
  logic [7:0] bias;
  logic [7:0] lut_addr;
  logic [7:0] tanh_in = 8'h00;
  logic       act_valid;
  logic       act_ready;
  logic [7:0] act_data;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  bit hold_off = 1'b0;
  bit rand_ready = 1'b0;

  neuron_mac_act #(.N(N), .Q(Q), .MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_last(in_last), .bias(bias),
    .lut_addr(lut_addr), .tanh_in(tanh_in),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Truncating (toward zero) Q7 tanh table.
  function automatic logic [7:0] tanh_lut(logic [7:0] a);
    real r;
    int  v;
    r = $tanh(real'($signed(a)) / 128.0) * 128.0;
    v = $rtoi(r);
    return v[7:0];
  endfunction

  // Wrap to the accumulator width, rescale, then saturate or truncate.
  function automatic logic [7:0] fold(longint s);
    longint m;
    longint v;
    m = 64'sd1 <<< ACC_W;
    v = s % m;
    if (v < 0) v += m;
    if (v >= m / 2) v -= m;
    v = v >>> Q;
`ifdef NEURON_SAT_EN
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`endif
    return v[7:0];
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // LUT emulation: registers the looked-up value on negedge.
  always @(negedge clk) tanh_in <= tanh_lut(lut_addr);

  // Downstream ready source.
  always @(negedge clk)
    act_ready = hold_off ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);

  // Reference model and per-cycle compare.
  longint     prods[$];
  longint     m_bias;
  longint     s;
  bit         m_ready = 1'b1;
  bit         m_valid = 1'b0;
  bit         m_look  = 1'b0;
  bit         m_ovf   = 1'b0;
  logic [7:0] m_addr  = 8'h00;
  logic [7:0] m_data  = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1; m_valid = 1'b0; m_look = 1'b0; m_ovf = 1'b0;
      m_addr = 8'h00; m_data = 8'h00;
      prods.delete();
    end else if (m_look) begin
      m_data  = tanh_lut(m_addr);
      m_valid = 1'b1;
      m_look  = 1'b0;
    end else if (m_valid) begin
      if (act_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end else if (in_valid) begin
      if (prods.size() == 0) m_bias = longint'($signed(bias));
      if (prods.size() == MAX_TERMS) m_ovf = 1'b1;
      prods.push_back(longint'($signed(in_x)) * longint'($signed(in_w)));
      if (in_last) begin
        s = m_bias * 128;
        foreach (prods[i]) s += prods[i];
        m_addr  = fold(s);
        m_ready = 1'b0;
        m_look  = 1'b1;
        prods.delete();
      end
    end
    #2;
    check("in_ready", in_ready, m_ready);
    check("act_valid", act_valid, m_valid);
    check("lut_addr", lut_addr, m_addr);
    check("act_data", act_data, m_data);
    check("ovf", ovf, m_ovf);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat and holds it until the block accepts it.
  task automatic send_beat(logic [7:0] x, logic [7:0] w, logic [7:0] b, logic last);
    bit rdy;
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_x = x; in_w = w; bias = b; in_last = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = in_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) check("beat accept timeout", 0, 1);
  endtask

  task automatic wait_act(output logic [7:0] a, output logic [7:0] d);
    bit seen;
    seen = 1'b0;
    a = 8'h00;
    d = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (act_valid) begin
        seen = 1'b1;
        a = lut_addr;
        d = act_data;
        break;
      end
    end
    step();
    check("act_valid seen", int'(seen), 1);
  endtask

  task automatic neuron1(logic [7:0] b, logic [7:0] x, logic [7:0] w,
                         logic [7:0] ea, logic [7:0] ed, string name);
    logic [7:0] a;
    logic [7:0] d;
    send_beat(x, w, b, 1'b1);
    wait_act(a, d);
    check({name, " lut_addr"}, a, ea);
    check({name, " act_data"}, d, ed);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    int nb;
    rst = 1'b1; in_valid = 1'b0; in_x = 8'h00; in_w = 8'h00; in_last = 1'b0; bias = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset act_valid", act_valid, 0);
    check("reset lut_addr", lut_addr, 0);
    check("reset act_data", act_data, 0);
    check("reset ovf", ovf, 0);
    step();

    neuron1(8'h00, 8'h40, 8'h40, 8'h20, 8'h1F, "t1");
    neuron1(8'h00, 8'h80, 8'h40, 8'hC0, 8'hC5, "t2");
    neuron1(8'h10, 8'h00, 8'h00, 8'h10, 8'h0F, "t3");

    for (int i = 0; i < 4; i++) send_beat(8'h7F, 8'h7F, 8'h00, i == 3);
    wait_act(a, d);
`ifdef NEURON_SAT_EN
    check("t4 lut_addr", a, 8'h7F);
    check("t4 act_data", d, 8'h61);
`else
    check("t4 lut_addr", a, 8'hF8);
    check("t4 act_data", d, 8'hF9);
`endif

    // Most-negative operands: product is +2^14, rescaled to +128.
`ifdef NEURON_SAT_EN
    neuron1(8'h00, 8'h80, 8'h80, 8'h7F, 8'h61, "t7");
`else
    neuron1(8'h00, 8'h80, 8'h80, 8'h80, 8'h9F, "t7");
`endif

    // Back-pressure: output must hold while act_ready is low.
    hold_off = 1'b1;
    send_beat(8'h40, 8'h40, 8'h00, 1'b1);
    wait_act(a, d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold act_valid", act_valid, 1);
      check("hold act_data", act_data, 8'h1F);
      check("hold in_ready", in_ready, 0);
      step();
    end
    hold_off = 1'b0;
    @(negedge clk);
    step();
    check("release act_valid", act_valid, 0);
    check("release in_ready", in_ready, 1);

    // Abort a partial neuron with reset.
    for (int i = 0; i < 3; i++) send_beat(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    neuron1(8'h00, 8'h40, 8'h40, 8'h20, 8'h1F, "t6");

    // Randomised neurons with random gaps and random downstream ready.
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      nb = $urandom_range(1, MAX_TERMS);
      for (int b = 0; b < nb; b++) begin
        send_beat(8'($urandom), 8'($urandom), 8'($urandom), b == nb - 1);
        repeat ($urandom_range(0, 1)) step();
      end
    end
    rand_ready = 1'b0;
    repeat (6) step();

    // Overflow: 17th beat sets ovf, which survives until reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      send_beat(8'($urandom), 8'($urandom), 8'h00, 1'b0);
      if (i == 16) check("ovf after 16 beats", ovf, 0);
      if (i == 17) check("ovf after 17 beats", ovf, 1);
    end
    send_beat(8'h11, 8'h22, 8'h00, 1'b1);
    wait_act(a, d);
    check("ovf sticky", ovf, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ovf cleared by rst", ovf, 0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
